// File: rtl/beer_tap_pkg.sv
// Shared types and constants for the beer tap valve stage.
// Optional feature macro: BEER_TAP_ABORT_EN (see beer_tap_valve.sv).
package beer_tap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POUR  = 2'd1,
        DRIP  = 2'd2,
        EMPTY = 2'd3
    } tap_state_t;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_LOW   = 2'd1;
    localparam logic [1:0] LVL_OK    = 2'd2;
    localparam logic [1:0] LVL_FULL  = 2'd3;

    // Quantise the remaining keg volume into the 2-bit level code.
    function automatic logic [1:0] keg_level(input logic [7:0] rem,
                                             input logic [7:0] full,
                                             input logic [7:0] quarter);
        if (rem == full)
            return LVL_FULL;
        else if (rem == 8'd0)
            return LVL_EMPTY;
        else if (rem <= quarter)
            return LVL_LOW;
        else
            return LVL_OK;
    endfunction

endpackage

// File: rtl/beer_tap_valve_edge.sv
// Registered rising-edge detector with configurable reset value of the
// previous-sample register.
module beer_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    // Remember the previous input level.
    always_ff @(posedge clk) begin
        if (reset)
            r_prev <= RESET_VAL;
        else
            r_prev <= i_d;
    end

    // Rising edge: high now, low on the previous clock.
    always_comb begin
        o_rise = i_d & ~r_prev;
    end

endmodule

// File: rtl/beer_tap_valve.sv
// Tap valve controller: times each pour, enforces a drip hold-off, tracks
// keg volume and reports the quantised level back to the draft controller.
// Optional macro BEER_TAP_ABORT_EN adds an `abort` input that ends a pour
// early (keg still debited, pour not counted).
module beer_tap_valve
    import beer_tap_pkg::*;
#(
    parameter int POUR_CYCLES = 8,
    parameter int DRIP_CYCLES = 4,
    parameter int KEG_POURS   = 12,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beer,
    input  logic             refill,
`ifdef BEER_TAP_ABORT_EN
    input  logic             abort,
`endif
    output logic             valve,
    output logic             busy,
    output logic             keg_empty,
    output logic [1:0]       beer_level,
    output logic [CNT_W-1:0] pour_count,
    output logic [1:0]       tap_state
);

    localparam int TMR_MAX = (POUR_CYCLES > DRIP_CYCLES) ? POUR_CYCLES : DRIP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [7:0]       KEG_FULL    = 8'(KEG_POURS);
    localparam logic [7:0]       KEG_QUARTER = 8'(KEG_POURS / 4);
    localparam logic [TMR_W-1:0] TMR_POUR    = TMR_W'(POUR_CYCLES);
    localparam logic [TMR_W-1:0] TMR_DRIP    = TMR_W'(DRIP_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(1);

    tap_state_t       r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [7:0]       r_remaining, w_remaining_nxt;
    logic [CNT_W-1:0] r_pour_count, w_pour_count_nxt;
    logic             w_req;
    logic             w_abort;

    beer_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_beer_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (beer),
        .o_rise (w_req)
    );

`ifdef BEER_TAP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // State, timer and keg/pour counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_remaining  <= KEG_FULL;
            r_pour_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_remaining  <= w_remaining_nxt;
            r_pour_count <= w_pour_count_nxt;
        end
    end

    // Next-state, timer and counter updates.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_remaining_nxt  = r_remaining;
        w_pour_count_nxt = r_pour_count;
        case (r_state)
            IDLE: begin
                if (refill) begin
                    w_remaining_nxt = KEG_FULL;
                end else if (w_req && (r_remaining != 8'd0)) begin
                    w_state_nxt = POUR;
                    w_timer_nxt = TMR_POUR;
                end
            end
            POUR: begin
                if (w_abort || (r_timer == TMR_LAST)) begin
                    w_state_nxt     = DRIP;
                    w_timer_nxt     = TMR_DRIP;
                    w_remaining_nxt = r_remaining - 8'd1;
                    if (!w_abort && (r_pour_count != '1))
                        w_pour_count_nxt = r_pour_count + CNT_W'(1);
                end else begin
                    w_timer_nxt = r_timer - TMR_LAST;
                end
            end
            DRIP: begin
                if (r_timer == TMR_LAST) begin
                    w_state_nxt = (r_remaining == 8'd0) ? EMPTY : IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_LAST;
                end
            end
            EMPTY: begin
                if (refill) begin
                    w_remaining_nxt = KEG_FULL;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        valve      = (r_state == POUR);
        busy       = (r_state == POUR) || (r_state == DRIP);
        keg_empty  = (r_state == EMPTY);
        tap_state  = r_state;
        pour_count = r_pour_count;
        beer_level = keg_level(r_remaining, KEG_FULL, KEG_QUARTER);
    end

endmodule

// File: tb/tb_beer_tap_valve.sv
// Directed self-checking bench for beer_tap_valve (POUR=8, DRIP=4, KEG=4).
module tb_beer_tap_valve;

    localparam int P = 8;
    localparam int D = 4;
    localparam int K = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       beer;
    logic       refill;
    logic       abort;
    logic       valve;
    logic       busy;
    logic       keg_empty;
    logic [1:0] beer_level;
    logic [7:0] pour_count;
    logic [1:0] tap_state;

    int n_vec  = 0;
    int n_miss = 0;

    beer_tap_valve #(
        .POUR_CYCLES (P),
        .DRIP_CYCLES (D),
        .KEG_POURS   (K),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .beer       (beer),
        .refill     (refill),
`ifdef BEER_TAP_ABORT_EN
        .abort      (abort),
`endif
        .valve      (valve),
        .busy       (busy),
        .keg_empty  (keg_empty),
        .beer_level (beer_level),
        .pour_count (pour_count),
        .tap_state  (tap_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Produce a rising edge of beer; returns right after the accepting edge.
    task automatic request();
        beer = 1'b0;
        tick();
        beer = 1'b1;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        beer   = 1'b1;
        refill = 1'b0;
        abort  = 1'b0;
        repeat (3) tick();
        chk("rst_valve", valve, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", keg_empty, 0);
        chk("rst_level", beer_level, 3);
        chk("rst_state", tap_state, 0);
        chk("rst_count", pour_count, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("held_beer_no_pour", valve, 0);
        chk("held_beer_state", tap_state, 0);

        // Refill and request together in IDLE: refill wins.
        beer = 1'b0;
        tick();
        beer   = 1'b1;
        refill = 1'b1;
        tick();
        refill = 1'b0;
        chk("refill_beats_req_valve", valve, 0);
        chk("refill_beats_req_state", tap_state, 0);
        beer = 1'b0;
        tick();

        // First pour, with a second rising edge during DRIP.
        beer = 1'b1;
        tick();
        for (int i = 0; i < P + D; i++) begin
            chk($sformatf("p1_valve_%0d", i), valve, (i < P) ? 1 : 0);
            chk($sformatf("p1_busy_%0d", i), busy, 1);
            chk($sformatf("p1_count_%0d", i), pour_count, (i < P) ? 0 : 1);
            chk($sformatf("p1_level_%0d", i), beer_level, (i < P) ? 3 : 2);
            if (i == P) beer = 1'b0;
            if (i == P + 1) beer = 1'b1;
            tick();
        end
        chk("p1_done_busy", busy, 0);
        chk("p1_done_valve", valve, 0);
        chk("p1_done_count", pour_count, 1);
        chk("p1_done_level", beer_level, 2);

        // Pours 2..4: levels 2, 1, 0.
        request();
        repeat (P + D) tick();
        chk("p2_level", beer_level, 2);
        request();
        repeat (P + D) tick();
        chk("p3_level", beer_level, 1);
        request();
        repeat (P + D) tick();
        chk("p4_level", beer_level, 0);
        chk("p4_count", pour_count, 4);
        chk("p4_empty", keg_empty, 1);
        chk("p4_state", tap_state, 3);
        request();
        chk("empty_req_valve", valve, 0);
        tick();
        chk("empty_req_valve2", valve, 0);
        chk("empty_req_state", tap_state, 3);

        // Refill from EMPTY, then a normal pour.
        refill = 1'b1;
        tick();
        refill = 1'b0;
        chk("refill_state", tap_state, 0);
        chk("refill_level", beer_level, 3);
        chk("refill_empty", keg_empty, 0);
        request();
        chk("post_refill_valve", valve, 1);
        repeat (P) tick();
        chk("post_refill_valve_off", valve, 0);
        chk("post_refill_count", pour_count, 5);
        chk("post_refill_level", beer_level, 2);
        repeat (D) tick();
        chk("post_refill_idle", tap_state, 0);

        // Reset at pour cycle 5 discards the partial pour.
        request();
        repeat (4) tick();
        chk("pre_reset_valve", valve, 1);
        reset = 1'b1;
        tick();
        chk("midpour_rst_valve", valve, 0);
        chk("midpour_rst_level", beer_level, 3);
        chk("midpour_rst_count", pour_count, 0);
        reset = 1'b0;
        tick();
        chk("midpour_rst_state", tap_state, 0);

`ifdef BEER_TAP_ABORT_EN
        // Abort at pour cycle 3.
        request();
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valve", valve, 0);
        chk("abort_state", tap_state, 2);
        chk("abort_level", beer_level, 2);
        chk("abort_count", pour_count, 0);
        repeat (D) tick();
        chk("abort_idle", tap_state, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
